bcd_to_twos: RTL and testbench

BCD_TO_TWOS -- requirements
Module: bcd_to_twos

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_adjust.sv | 16 +
 rtl/bcd_to_twos.sv | 129 ++++++++++++
 tb/tb_bcd_to_twos.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the 3-digit BCD to 8-bit two's complement converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int N_SHIFTS    = 10;
    localparam int MAX_POS     = 127;
    localparam int MAX_NEG_MAG = 128;
    localparam int CNT_W       = 4;

    function automatic logic digit_invalid(input bcd_digit_t d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for right-shift BCD to binary: a nibble of 8 or more loses 3.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd8) begin
            digit_out = digit_in - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_twos.sv
// Sequential 3-digit BCD to 8-bit two's complement converter with range/digit checking.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | waiting for start; operands captured on start
//   ST_CONVERT | one right shift + nibble correction per cycle, 10 total
//   ST_FINISH  | range/sign resolution, registers data/err, pulses done
module bcd_to_twos
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] cent,
    input  logic [3:0] dec,
    input  logic [3:0] uni,
    input  logic       sign,
    output logic       busy,
    output logic       done,
    output logic [7:0] data,
    output logic       err
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [11:0]        bcd, bcd_next;
    logic [9:0]         bin, bin_next;
    logic               neg, neg_next;
    logic               digit_err, digit_err_next;
    logic               busy_next, done_next, err_next;
    logic [7:0]         data_next;

    logic [21:0]        shifted;
    logic [11:0]        bcd_adj;
    logic               range_err;
    logic               res_err;
    logic [7:0]         res_data;

    assign shifted = {1'b0, bcd, bin[9:1]};

    for (genvar g = 0; g < 3; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (shifted[10 + 4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
        );
    end

    // After the last shift bin holds the full magnitude (0..999 fits in 10 bits).
    always_comb begin
        range_err = neg ? (bin > 10'(MAX_NEG_MAG)) : (bin > 10'(MAX_POS));
        res_err   = digit_err | range_err;
        res_data  = 8'h00;
        if (!res_err) begin
            res_data = neg ? (~bin[7:0]) + 8'd1 : bin[7:0];
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        bcd_next       = bcd;
        bin_next       = bin;
        neg_next       = neg;
        digit_err_next = digit_err;
        data_next      = data;
        err_next       = err;
        done_next      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    bcd_next       = {cent, dec, uni};
                    bin_next       = '0;
                    cnt_next       = '0;
                    neg_next       = sign;
                    digit_err_next = digit_invalid(cent) | digit_invalid(dec)
                                   | digit_invalid(uni);
                    state_next     = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                bcd_next = bcd_adj;
                bin_next = shifted[9:0];
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_W'(N_SHIFTS - 1)) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                data_next  = res_data;
                err_next   = res_err;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bcd       <= '0;
            bin       <= '0;
            neg       <= 1'b0;
            digit_err <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data      <= 8'h00;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bcd       <= bcd_next;
            bin       <= bin_next;
            neg       <= neg_next;
            digit_err <= digit_err_next;
            busy      <= busy_next;
            done      <= done_next;
            data      <= data_next;
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_bcd_to_twos.sv
// Self-checking bench for bcd_to_twos: directed cases plus randomized conversions vs. arithmetic model.
module tb_bcd_to_twos;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] cent, dec, uni;
    logic       sign;
    logic       busy, done, err;
    logic [7:0] data;

    int n_pass  = 0;
    int n_total = 0;

    bcd_to_twos dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cent  (cent),
        .dec   (dec),
        .uni   (uni),
        .sign  (sign),
        .busy  (busy),
        .done  (done),
        .data  (data),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: decimal arithmetic on the digits, then the sign/range rules.
    task automatic ref_model(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                             input logic s, output logic [7:0] rdata, output logic rerr);
        int mag;
        mag  = 100 * int'(c) + 10 * int'(d) + int'(u);
        rerr = (c > 9) || (d > 9) || (u > 9) || (s ? (mag > 128) : (mag > 127));
        if (rerr)   rdata = 8'h00;
        else if (s) rdata = 8'((256 - mag) % 256);
        else        rdata = 8'(mag);
    endtask

    task automatic do_conv(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                           input logic s, input bit scramble);
        logic [7:0] ed;
        logic       ee;
        int         n;
        int         nbusy;
        ref_model(c, d, u, s, ed, ee);
        cent = c; dec = d; uni = u; sign = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nbusy = busy ? 1 : 0;
        n = 0;
        while (!done && n < 20) begin
            if (scramble && n >= 1 && n <= 6) begin
                cent  = 4'($urandom_range(0, 15));
                dec   = 4'($urandom_range(0, 15));
                uni   = 4'($urandom_range(0, 15));
                sign  = 1'($urandom_range(0, 1));
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (busy) nbusy++;
        end
        start = 1'b0;
        check("latency", n, 11);
        check("data", data, ed);
        check("err", err, ee);
        check("busy_cycles", nbusy, 11);
        check("busy_in_done", busy, 0);
        @(posedge clk); #1;
        check("done_single", done, 0);
        check("data_hold", data, ed);
        check("err_hold", err, ee);
    endtask

    initial begin
        int prev;
        int npulse;
        int ndone;
        logic [3:0] rc, rd, ru;

        rst = 1'b0; start = 1'b0; cent = '0; dec = '0; uni = '0; sign = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", data, 0);
        check("rst_err", err, 0);

        // reset wins over start on the same edge
        start = 1'b1;
        @(posedge clk); #1;
        check("rst_prio_busy", busy, 0);
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        do_conv(4'd1, 4'd2, 4'd7, 1'b0, 1'b0);
        check("c127_const", data, 8'h7F);
        do_conv(4'd1, 4'd2, 4'd8, 1'b1, 1'b0);
        check("cm128_const", data, 8'h80);
        do_conv(4'd0, 4'd4, 4'd2, 1'b1, 1'b0);
        check("cm42_const", data, 8'hD6);
        do_conv(4'd1, 4'd2, 4'd7, 1'b0, 1'b0);
        do_conv(4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        check("negzero_const", data, 8'h00);
        do_conv(4'd1, 4'd2, 4'd8, 1'b0, 1'b0);
        check("c128pos_err", err, 1);
        do_conv(4'd9, 4'd9, 4'd9, 1'b1, 1'b0);
        do_conv(4'd0, 4'd0, 4'hA, 1'b0, 1'b0);
        check("digit_err", err, 1);
        do_conv(4'd0, 4'd9, 4'd9, 1'b1, 1'b1);
        check("scramble_const", data, 8'h9D);

        // abort at edge k+5
        do_conv(4'd0, 4'd6, 4'd4, 1'b0, 1'b0);
        cent = 4'd0; dec = 4'd9; uni = 4'd9; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_data", data, 0);
        check("abort_err", err, 0);
        rst = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_conv(4'd0, 4'd9, 4'd9, 1'b0, 1'b0);

        // start held high: one result every 12 cycles
        cent = 4'd0; dec = 4'd5; uni = 4'd0; sign = 1'b0; start = 1'b1;
        prev = -1;
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                check("b2b_data", data, 8'h32);
                check("b2b_err", err, 0);
                if (prev >= 0) check("b2b_period", i - prev, 12);
                prev = i;
                npulse++;
            end
        end
        start = 1'b0;
        check("b2b_pulses", npulse, 3);
        repeat (14) @(posedge clk);
        #1;

        for (int t = 0; t < 30; t++) begin
            rc = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
            rd = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            ru = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            do_conv(rc, rd, ru, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
